// File: rtl/run_checker_pkg.sv
// run_checker_pkg: shared types and constants for the run_checker harness.
//   state_e     : checker FSM states (HOLD, RUN, PASS, FAIL).
//   fail_code_e : failure cause reported on fail_code.
//   PC_W        : width of the processor program counter.
package run_checker_pkg;

   localparam int unsigned PC_W        = 32;
   localparam int unsigned FAIL_CODE_W = 2;

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      RUN  = 2'd1,
      PASS = 2'd2,
      FAIL = 2'd3
   } state_e;

   typedef enum logic [FAIL_CODE_W-1:0] {
      FC_NONE     = 2'd0,
      FC_MISMATCH = 2'd1,
      FC_TIMEOUT  = 2'd2,
      FC_HALT     = 2'd3
   } fail_code_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that stops at LIMIT.
// Ports:
//   clk        : clock
//   clr_n      : synchronous active-low clear
//   en         : count enable
//   count      : registered count value
//   at_limit_c : combinational flag, count == LIMIT
module sat_counter #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned LIMIT = 15
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic             at_limit_c
);

   assign at_limit_c = (count == WIDTH'(LIMIT));

   // Count while enabled, never past LIMIT.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         count <= '0;
      end else if (en && !at_limit_c) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/run_checker.sv
// run_checker: self-checking harness for a MIPS processor under test.
// Holds the processor in reset for HOLD_CYCLES after its own reset releases,
// then matches data-memory stores in order against an expected table and
// reports PASS or FAIL (mismatch, timeout, or optional halt detection).
// Optional feature macro: RUN_CHECKER_PC_HALT_EN (branch-to-self halt detect).
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   cpu_reset           : active-high reset to the processor
//   memwrite/dataaddr/writedata : observed store bus
//   pc                  : processor PC (halt detection only)
//   exp_addr/exp_data   : packed expected stores, entry i at [i*W +: W]
//   done/pass/fail      : terminal status flags
//   fail_code           : 0 none, 1 mismatch, 2 timeout, 3 halt
//   match_count         : stores matched so far
//   cycle_count         : cycles spent in RUN
//   fail_addr/fail_data : store (or pc) captured on failure
module run_checker
   import run_checker_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned NUM_CHECKS  = 4,
   parameter int unsigned TIMEOUT     = 1024,
   parameter int unsigned HOLD_CYCLES = 3
) (
   input  logic                           clk,
   input  logic                           reset,
   output logic                           cpu_reset,
   input  logic                           memwrite,
   input  logic [ADDR_W-1:0]              dataaddr,
   input  logic [DATA_W-1:0]              writedata,
   input  logic [PC_W-1:0]                pc,
   input  logic [NUM_CHECKS*ADDR_W-1:0]   exp_addr,
   input  logic [NUM_CHECKS*DATA_W-1:0]   exp_data,
   output logic                           done,
   output logic                           pass,
   output logic                           fail,
   output logic [FAIL_CODE_W-1:0]         fail_code,
   output logic [$clog2(NUM_CHECKS+1)-1:0] match_count,
   output logic [$clog2(TIMEOUT+1)-1:0]   cycle_count,
   output logic [ADDR_W-1:0]              fail_addr,
   output logic [DATA_W-1:0]              fail_data
);

   localparam int unsigned MC_W = $clog2(NUM_CHECKS + 1);
   localparam int unsigned CC_W = $clog2(TIMEOUT + 1);
   localparam int unsigned HC_W = $clog2(HOLD_CYCLES + 1);

   state_e              state_q, state_d;
   fail_code_e          fc_q, fc_d;
   logic                cpu_reset_d;
   logic [MC_W-1:0]     match_d;
   logic [ADDR_W-1:0]   fail_addr_d;
   logic [DATA_W-1:0]   fail_data_d;
   logic [ADDR_W-1:0]   sel_addr_c;
   logic [DATA_W-1:0]   sel_data_c;
   logic                last_c;
   logic                hold_tc_c, hold_done_c;
   logic                cyc_tc_c, timeout_c;
   logic                cyc_en_c;
   logic [HC_W-1:0]     unused_hold_count;

   assign fail_code = FAIL_CODE_W'(fc_q);

   // Cycles with cpu_reset asserted after checker reset releases.
   sat_counter #(
      .WIDTH (HC_W),
      .LIMIT (HOLD_CYCLES - 1)
   ) u_hold_cnt (
      .clk        (clk),
      .clr_n      (reset),
      .en         (state_q == HOLD),
      .count      (unused_hold_count),
      .at_limit_c (hold_tc_c)
   );

   // RUN cycle counter; freezes on the edge that leaves RUN.
   assign cyc_en_c = (state_q == RUN) && (state_d == RUN);

   sat_counter #(
      .WIDTH (CC_W),
      .LIMIT (TIMEOUT - 1)
   ) u_cycle_cnt (
      .clk        (clk),
      .clr_n      (reset),
      .en         (cyc_en_c),
      .count      (cycle_count),
      .at_limit_c (cyc_tc_c)
   );

   assign hold_done_c = (state_q == HOLD) && hold_tc_c;
   assign timeout_c   = (state_q == RUN) && cyc_tc_c;
   assign last_c      = (match_count == MC_W'(NUM_CHECKS - 1));

   // Select the expected entry indexed by match_count.
   always_comb begin
      sel_addr_c = '0;
      sel_data_c = '0;
      for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
         if (match_count == MC_W'(i)) begin
            sel_addr_c = exp_addr[i*ADDR_W +: ADDR_W];
            sel_data_c = exp_data[i*DATA_W +: DATA_W];
         end
      end
   end

`ifdef RUN_CHECKER_PC_HALT_EN
   logic [PC_W-1:0] pc_prev;
   logic            pc_same_q;
   logic            pc_same_c;
   logic            halt_c;

   assign pc_same_c = (pc == pc_prev);
   // Halt = PC unchanged on two consecutive RUN cycles.
   assign halt_c    = (state_q == RUN) && pc_same_q && pc_same_c &&
                      (match_count < MC_W'(NUM_CHECKS));

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_prev   <= '0;
         pc_same_q <= 1'b0;
      end else begin
         pc_prev   <= pc;
         pc_same_q <= (state_q == RUN) && pc_same_c;
      end
   end
`else
   logic [PC_W-1:0] unused_pc;
   assign unused_pc = pc;
`endif

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      fc_d        = fc_q;
      cpu_reset_d = cpu_reset;
      match_d     = match_count;
      fail_addr_d = fail_addr;
      fail_data_d = fail_data;

      case (state_q)
         HOLD: begin
            cpu_reset_d = 1'b1;
            if (hold_done_c) begin
               state_d     = RUN;
               cpu_reset_d = 1'b0;
            end
         end

         RUN: begin
            cpu_reset_d = 1'b0;
            if (memwrite) begin
               if ((dataaddr == sel_addr_c) && (writedata == sel_data_c)) begin
                  match_d = match_count + MC_W'(1);
                  if (last_c) begin
                     state_d = PASS;
                  end
               end else begin
                  state_d     = FAIL;
                  fc_d        = FC_MISMATCH;
                  fail_addr_d = dataaddr;
                  fail_data_d = writedata;
               end
            end
`ifdef RUN_CHECKER_PC_HALT_EN
            if ((state_d == RUN) && halt_c) begin
               state_d     = FAIL;
               fc_d        = FC_HALT;
               fail_addr_d = ADDR_W'(pc);
            end
`endif
            // Timeout only if the store did not already decide this edge.
            if ((state_d == RUN) && timeout_c) begin
               state_d = FAIL;
               fc_d    = FC_TIMEOUT;
            end
            if (state_d != RUN) begin
               cpu_reset_d = 1'b1;
            end
         end

         PASS, FAIL: begin
            cpu_reset_d = 1'b1;
         end

         default: begin
            state_d     = HOLD;
            cpu_reset_d = 1'b1;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= HOLD;
         cpu_reset   <= 1'b1;
         done        <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
         fc_q        <= FC_NONE;
         match_count <= '0;
         fail_addr   <= '0;
         fail_data   <= '0;
      end else begin
         state_q     <= state_d;
         cpu_reset   <= cpu_reset_d;
         done        <= (state_d == PASS) || (state_d == FAIL);
         pass        <= (state_d == PASS);
         fail        <= (state_d == FAIL);
         fc_q        <= fc_d;
         match_count <= match_d;
         fail_addr   <= fail_addr_d;
         fail_data   <= fail_data_d;
      end
   end

endmodule

// File: tb/tb_run_checker.sv
// tb_run_checker: randomized self-checking bench for run_checker.
// A scenario is a store schedule indexed by RUN cycle plus an expected table;
// a reference model walks the schedule to predict the decision cycle, cause,
// final counts and captured store, which are checked per cycle and at the end.
module tb_run_checker;

   localparam int NC   = 4;
   localparam int TO   = 32;
   localparam int HC   = 3;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int MC_W = $clog2(NC + 1);
   localparam int CC_W = $clog2(TO + 1);
   localparam int NCYC = TO + 2;

   logic                 clk;
   logic                 reset;
   logic                 cpu_reset;
   logic                 memwrite;
   logic [AW-1:0]        dataaddr;
   logic [DW-1:0]        writedata;
   logic [31:0]          pc;
   logic [NC*AW-1:0]     exp_addr;
   logic [NC*DW-1:0]     exp_data;
   logic                 done, pass, fail;
   logic [1:0]           fail_code;
   logic [MC_W-1:0]      match_count;
   logic [CC_W-1:0]      cycle_count;
   logic [AW-1:0]        fail_addr;
   logic [DW-1:0]        fail_data;

   int checks   = 0;
   int failures = 0;

   // Scenario description
   logic [AW-1:0] tbl_addr [NC];
   logic [DW-1:0] tbl_data [NC];
   logic          st_we    [NCYC];
   logic [AW-1:0] st_addr  [NCYC];
   logic [DW-1:0] st_data  [NCYC];

   // Model predictions
   int            m_dec;
   int            m_code;
   logic          m_pass;
   logic [AW-1:0] m_faddr;
   logic [DW-1:0] m_fdata;
   int            mc_before [NCYC];

   run_checker #(
      .DATA_W      (DW),
      .ADDR_W      (AW),
      .NUM_CHECKS  (NC),
      .TIMEOUT     (TO),
      .HOLD_CYCLES (HC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cpu_reset   (cpu_reset),
      .memwrite    (memwrite),
      .dataaddr    (dataaddr),
      .writedata   (writedata),
      .pc          (pc),
      .exp_addr    (exp_addr),
      .exp_data    (exp_data),
      .done        (done),
      .pass        (pass),
      .fail        (fail),
      .fail_code   (fail_code),
      .match_count (match_count),
      .cycle_count (cycle_count),
      .fail_addr   (fail_addr),
      .fail_data   (fail_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Free-running PC so halt detection never fires when it is built in.
   initial begin
      pc = 32'h0040_0000;
      forever begin
         @(negedge clk);
         pc = pc + 32'd4;
      end
   end

   task automatic new_table();
      for (int i = 0; i < NC; i++) begin
         tbl_addr[i] = $urandom() & 32'hFFFF_FFFC;
         tbl_data[i] = $urandom();
      end
   endtask

   task automatic clear_stores();
      for (int c = 0; c < NCYC; c++) begin
         st_we[c]   = 1'b0;
         st_addr[c] = '0;
         st_data[c] = '0;
      end
   endtask

   task automatic put_store(input int c, input int idx, input bit corrupt);
      logic [31:0] mask;
      st_we[c]   = 1'b1;
      st_addr[c] = tbl_addr[idx];
      st_data[c] = tbl_data[idx];
      if (corrupt) begin
         mask = 32'h1 << $urandom_range(31, 0);
         if ($urandom_range(1, 0) == 1) st_addr[c] = st_addr[c] ^ mask;
         else                           st_data[c] = st_data[c] ^ mask;
      end
   endtask

   // Reference model: in-order matching against the table with timeout.
   task automatic build_model();
      int m;
      bit decided;
      m = 0; decided = 0;
      m_dec = TO + 100; m_code = 0; m_pass = 1'b0; m_faddr = '0; m_fdata = '0;
      for (int c = 0; c < NCYC; c++) begin
         mc_before[c] = m;
         if (!decided && c < TO) begin
            if (st_we[c]) begin
               if (st_addr[c] == tbl_addr[m] && st_data[c] == tbl_data[m]) begin
                  m++;
                  if (m == NC) begin
                     decided = 1; m_pass = 1'b1; m_dec = c;
                  end
               end else begin
                  decided = 1; m_code = 1; m_dec = c;
                  m_faddr = st_addr[c]; m_fdata = st_data[c];
               end
            end
            if (!decided && c == TO - 1) begin
               decided = 1; m_code = 2; m_dec = c;
            end
         end
      end
   endtask

   task automatic check_reset_values(input string name);
      checks++;
      if (cpu_reset !== 1'b1 || done !== 1'b0 || pass !== 1'b0 || fail !== 1'b0 ||
          fail_code !== 2'd0) begin
         failures++;
         $display("FAIL %s reset_flags got cpu_reset=%b done=%b pass=%b fail=%b code=%0d exp 1/0/0/0/0",
                  name, cpu_reset, done, pass, fail, fail_code);
      end
      checks++;
      if (match_count !== '0 || cycle_count !== '0 || fail_addr !== '0 || fail_data !== '0) begin
         failures++;
         $display("FAIL %s reset_counts got match=%0d cycle=%0d faddr=%h fdata=%h exp all 0",
                  name, match_count, cycle_count, fail_addr, fail_data);
      end
   endtask

   // Reset, HOLD, then drive the schedule; abort_at >= 0 pulls reset mid-run.
   task automatic run_scenario(input string name, input int abort_at);
      int exp_cc;
      logic exp_done;
      build_model();
      for (int i = 0; i < NC; i++) begin
         exp_addr[i*AW +: AW] = tbl_addr[i];
         exp_data[i*DW +: DW] = tbl_data[i];
      end
      @(negedge clk);
      reset = 1'b0; memwrite = 1'b0;
      @(posedge clk); @(negedge clk);
      check_reset_values(name);
      reset = 1'b1;
      for (int k = 1; k <= HC; k++) begin
         @(posedge clk); @(negedge clk);
         if (k < HC) begin
            checks++;
            if (cpu_reset !== 1'b1 || done !== 1'b0) begin
               failures++;
               $display("FAIL %s hold k=%0d got cpu_reset=%b done=%b exp 1/0", name, k, cpu_reset, done);
            end
         end
      end
      for (int c = 0; c < NCYC; c++) begin
         exp_done = (c > m_dec);
         exp_cc   = (c <= m_dec) ? c : m_dec;
         checks++;
         if (done !== exp_done || cpu_reset !== exp_done) begin
            failures++;
            $display("FAIL %s run_flags c=%0d got done=%b cpu_reset=%b exp %b", name, c, done, cpu_reset, exp_done);
         end
         checks++;
         if (cycle_count !== CC_W'(exp_cc)) begin
            failures++;
            $display("FAIL %s cycle_count c=%0d got %0d exp %0d", name, c, cycle_count, exp_cc);
         end
         checks++;
         if (match_count !== MC_W'(mc_before[c])) begin
            failures++;
            $display("FAIL %s match_count c=%0d got %0d exp %0d", name, c, match_count, mc_before[c]);
         end
         if (c == abort_at) begin
            reset = 1'b0; memwrite = 1'b0;
            @(posedge clk); @(negedge clk);
            check_reset_values({name, "_abort"});
            return;
         end
         memwrite  = st_we[c];
         dataaddr  = st_we[c] ? st_addr[c] : $urandom();
         writedata = st_we[c] ? st_data[c] : $urandom();
         @(posedge clk); @(negedge clk);
      end
      memwrite = 1'b0;
      checks++;
      if (done !== 1'b1 || cpu_reset !== 1'b1 || pass !== m_pass || fail !== !m_pass) begin
         failures++;
         $display("FAIL %s final_flags got done=%b cpu_reset=%b pass=%b fail=%b exp 1/1/%b/%b",
                  name, done, cpu_reset, pass, fail, m_pass, !m_pass);
      end
      checks++;
      if (fail_code !== 2'(m_code)) begin
         failures++;
         $display("FAIL %s fail_code got %0d exp %0d", name, fail_code, m_code);
      end
      checks++;
      if (match_count !== MC_W'(mc_before[NCYC-1]) || cycle_count !== CC_W'(m_dec)) begin
         failures++;
         $display("FAIL %s final_counts got match=%0d cycle=%0d exp %0d/%0d",
                  name, match_count, cycle_count, mc_before[NCYC-1], m_dec);
      end
      checks++;
      if (fail_addr !== m_faddr || fail_data !== m_fdata) begin
         failures++;
         $display("FAIL %s capture got addr=%h data=%h exp %h/%h", name, fail_addr, fail_data, m_faddr, m_fdata);
      end
   endtask

   task automatic test_reset();
      new_table(); clear_stores();
      put_store(1, 0, 1'b0);
      run_scenario("reset", 3);
   endtask

   task automatic test_pass_random();
      int c;
      new_table(); clear_stores();
      c = $urandom_range(5, 0);
      for (int j = 0; j < NC; j++) begin
         put_store(c, j, 1'b0);
         c += $urandom_range(6, 1);
      end
      run_scenario("pass_random", -1);
   endtask

   task automatic test_mismatch();
      new_table(); clear_stores();
      tbl_addr[0] = 32'd80; tbl_data[0] = 32'd5;
      tbl_addr[1] = 32'd84; tbl_data[1] = 32'd7;
      put_store(3, 0, 1'b0);
      put_store(9, 1, 1'b0);
      st_data[9] = 32'd6;
      run_scenario("mismatch", -1);
   endtask

   task automatic test_timeout();
      new_table(); clear_stores();
      run_scenario("timeout_idle", -1);
      new_table(); clear_stores();
      put_store(4, 0, 1'b0);
      put_store(TO - 1, 1, 1'b0);
      run_scenario("timeout_partial_match", -1);
   endtask

   task automatic test_timeout_edges();
      new_table(); clear_stores();
      put_store(0, 0, 1'b0); put_store(1, 1, 1'b0); put_store(2, 2, 1'b0);
      put_store(TO - 1, 3, 1'b0);
      run_scenario("final_on_timeout", -1);
      new_table(); clear_stores();
      put_store(0, 0, 1'b0);
      put_store(TO - 1, 1, 1'b1);
      run_scenario("mismatch_on_timeout", -1);
   endtask

   task automatic test_back_to_back();
      new_table(); clear_stores();
      for (int j = 0; j < NC; j++) put_store(5 + j, j, 1'b0);
      put_store(5 + NC, 0, 1'b1);
      run_scenario("back_to_back", -1);
   endtask

   task automatic test_midrun_reset();
      new_table(); clear_stores();
      put_store(2, 0, 1'b0);
      put_store(4, 1, 1'b0);
      run_scenario("midrun_abort", 4);
      clear_stores();
      for (int j = 0; j < NC; j++) put_store(1 + 2 * j, j, 1'b0);
      run_scenario("after_abort", -1);
   endtask

   task automatic test_random();
      int c, nst, idx;
      for (int it = 0; it < 8; it++) begin
         new_table(); clear_stores();
         nst = $urandom_range(NC + 1, 1);
         c   = $urandom_range(6, 0);
         for (int j = 0; j < nst; j++) begin
            if (c >= NCYC) break;
            idx = (j < NC) ? j : $urandom_range(NC - 1, 0);
            put_store(c, idx, $urandom_range(4, 0) == 0);
            c += $urandom_range(8, 1);
         end
         run_scenario("random", -1);
      end
   endtask

   initial begin
      reset     = 1'b0;
      memwrite  = 1'b0;
      dataaddr  = '0;
      writedata = '0;
      exp_addr  = '0;
      exp_data  = '0;
      test_reset();
      test_pass_random();
      test_mismatch();
      test_timeout();
      test_timeout_edges();
      test_back_to_back();
      test_midrun_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/run_checker.md
Name: run_checker

Overview:
- Synthesizable, parametrised self-checking harness for the single-cycle/pipelined MIPS `top`.
- Generates the processor reset sequence and watches the data-memory write bus (`memwrite`, `dataaddr`, `writedata`).
- Matches observed stores in order against an expected table, and raises PASS/FAIL with a cycle count and failure cause.
- Replaces hand-inspected waveform runs; it sits beside `top` in a bench or on the board (done/pass/fail to LEDs).

Parameters:
- DATA_W, 32, width of writedata and expected data.
- ADDR_W, 32, width of dataaddr and expected address.
- NUM_CHECKS, 4, number of expected stores (≥1).
- TIMEOUT, 1024, cycles allowed in RUN before timeout failure (≥2).
- HOLD_CYCLES, 3, cycles cpu_reset is held high after checker reset releases (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- cpu_reset  out  1  active-high reset driven to the processor under test.
- memwrite  in  1  processor store strobe.
- dataaddr  in  ADDR_W  store address.
- writedata  in  DATA_W  store data.
- pc  in  32  processor PC; used only with PC_HALT_EN.
- exp_addr  in  NUM_CHECKS*ADDR_W  expected addresses; entry i is bits [i*ADDR_W +: ADDR_W].
- exp_data  in  NUM_CHECKS*DATA_W  expected data, same packing.
- done  out  1  terminal state reached.
- pass  out  1  all checks matched.
- fail  out  1  failure detected.
- fail_code  out  2  0 none, 1 mismatch, 2 timeout, 3 halt.
- match_count  out  $clog2(NUM_CHECKS+1)  stores matched so far.
- cycle_count  out  $clog2(TIMEOUT+1)  cycles spent in RUN.
- fail_addr  out  ADDR_W  dataaddr captured on the failing store.
- fail_data  out  DATA_W  writedata captured on the failing store.

Behaviour:
- Reset (reset==0 at posedge):
  - state=HOLD, cpu_reset=1.
  - done/pass/fail=0, fail_code=0.
  - match_count, cycle_count, fail_addr, fail_data = 0; hold counter = 0.
- HOLD:
  - cpu_reset=1; hold counter increments each cycle.
  - After HOLD_CYCLES cycles, go to RUN and clear cpu_reset in the same edge.
  - memwrite is ignored in HOLD.
- RUN:
  - cpu_reset=0; cycle_count increments each cycle.
  - On memwrite=1, compare {dataaddr, writedata} with entry match_count.
  - Exact match: match_count+1. If this was entry NUM_CHECKS-1, go to PASS.
  - Any bit differs: go to FAIL, fail_code=1, capture dataaddr/writedata into fail_addr/fail_data.
  - memwrite=0: no compare.
- Timeout: when cycle_count==TIMEOUT-1 in RUN and the state does not move to PASS/FAIL that edge, go to FAIL with fail_code=2.
- Simultaneous events:
  - Final match on the timeout cycle → PASS.
  - Mismatch on the timeout cycle → fail_code=1, not 2.
- PASS/FAIL are terminal until reset:
  - done=1; pass or fail=1 (never both).
  - cpu_reset=1 to freeze the processor.
  - Counters and capture registers hold their values.
- All outputs are registered; flags become visible one cycle after the deciding store.
- Reset mid-run aborts immediately to the reset values above and restarts the HOLD sequence.

Optional Feature:
- Macro: RUN_CHECKER_PC_HALT_EN.
- Defined: a PC equal to its previous-cycle value for 2 consecutive RUN cycles (branch-to-self halt loop) with match_count<NUM_CHECKS → FAIL, fail_code=3, fail_addr=pc.
  - Priority: match/mismatch > halt > timeout.
- Undefined: pc is unused, no PC register is built, fail_code=3 is never produced.

Decomposition:
- Package run_checker_pkg:
  - state enum {HOLD, RUN, PASS, FAIL}.
  - fail_code enum {FC_NONE, FC_MISMATCH, FC_TIMEOUT, FC_HALT}.
- One sub-module, sat_counter:
  - Parametrised width/limit, synchronous active-low clear, enable, terminal-count output.
  - Instanced for the hold counter and cycle_count.

Test Plan:
- HOLD_CYCLES=3, release reset → cpu_reset high exactly 3 cycles after release, then 0; cycle_count starts at 0.
- NUM_CHECKS=1, exp={addr 84, data 7}, store (84,7) at RUN cycle 20 → pass=1, done=1, match_count=1, fail_code=0, cpu_reset=1.
- NUM_CHECKS=2, exp={(80,5),(84,7)}, stores (80,5) then (84,6) → fail=1, fail_code=1, match_count=1, fail_addr=84, fail_data=6.
- TIMEOUT=16, no stores → fail at cycle_count=15, fail_code=2.
- Final matching store on cycle 15 with TIMEOUT=16 → pass=1, fail=0.
- Pull reset low mid-RUN after 1 match, then release → all outputs zero, HOLD repeats, match_count restarts from 0.
